// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order retirement controller for the ROB head.
// Samples a ready head in IDLE and commits it one cycle later. A store first
// waits in STORE_WAIT for the memory ack. A mispredicted branch/jump commits
// through FLUSH, which also redirects the front end.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global ready; low freezes the block
//   head_*              ROB head entry (valid, ready, type, mispred, rd, value, tag, target)
//   store_ack           memory unit has performed the committed store
//   commit_en           one-cycle pulse, ROB pops head
//   reg_wr_*            register-file update port (enable, index, data, tag)
//   store_req           level request to execute the head store
//   flush, flush_pc     one-cycle redirect pulse and target PC
//   commit_cnt          retired-instruction count
`timescale 1ns/1ps
module commit_ctrl #(
    parameter int unsigned ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 head_valid,
    input  logic                 head_ready,
    input  logic [1:0]           head_type,
    input  logic                 head_mispred,
    input  logic [4:0]           head_rd,
    input  logic [31:0]          head_value,
    input  logic [ROB_IDX_W-1:0] head_tag,
    input  logic [31:0]          head_target,
    input  logic                 store_ack,
    output logic                 commit_en,
    output logic                 reg_wr_en,
    output logic [4:0]           reg_wr_rd,
    output logic [31:0]          reg_wr_data,
    output logic [ROB_IDX_W-1:0] reg_wr_tag,
    output logic                 store_req,
    output logic                 flush,
    output logic [31:0]          flush_pc,
    output logic [31:0]          commit_cnt
);

    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_STORE_WAIT,
        S_FLUSH
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             lat_type_q, lat_type_d;
    logic [4:0]             lat_rd_q, lat_rd_d;
    logic [31:0]            lat_value_q, lat_value_d;
    logic [ROB_IDX_W-1:0]   lat_tag_q, lat_tag_d;
    logic [31:0]            lat_target_q, lat_target_d;
    logic                   commit_en_q, commit_en_d;
    logic                   reg_wr_en_q, reg_wr_en_d;
    logic [4:0]             reg_wr_rd_q, reg_wr_rd_d;
    logic [31:0]            reg_wr_data_q, reg_wr_data_d;
    logic [ROB_IDX_W-1:0]   reg_wr_tag_q, reg_wr_tag_d;
    logic                   store_req_q, store_req_d;
    logic                   flush_q, flush_d;
    logic [31:0]            flush_pc_q, flush_pc_d;
    logic [31:0]            commit_cnt_q, commit_cnt_d;

    // Next-state and registered-output decode
    always_comb begin
        state_d       = state_q;
        lat_type_d    = lat_type_q;
        lat_rd_d      = lat_rd_q;
        lat_value_d   = lat_value_q;
        lat_tag_d     = lat_tag_q;
        lat_target_d  = lat_target_q;
        commit_en_d   = 1'b0;
        reg_wr_en_d   = 1'b0;
        reg_wr_rd_d   = reg_wr_rd_q;
        reg_wr_data_d = reg_wr_data_q;
        reg_wr_tag_d  = reg_wr_tag_q;
        store_req_d   = store_req_q;
        flush_d       = 1'b0;
        flush_pc_d    = flush_pc_q;
        commit_cnt_d  = commit_cnt_q;

        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (head_valid && head_ready) begin
                        lat_type_d   = head_type;
                        lat_rd_d     = head_rd;
                        lat_value_d  = head_value;
                        lat_tag_d    = head_tag;
                        lat_target_d = head_target;
                        if (head_type == TYPE_STORE) begin
                            state_d     = S_STORE_WAIT;
                            store_req_d = 1'b1;
                        end else if (head_type == TYPE_BRANCH && head_mispred) begin
                            state_d = S_FLUSH;
                        end else begin
                            state_d = S_COMMIT;
                        end
                    end
                end
                S_STORE_WAIT: begin
                    if (store_ack) begin
                        state_d     = S_COMMIT;
                        store_req_d = 1'b0;
                    end
                end
                default: begin
                    // COMMIT/FLUSH: a pulse shown while rdy was high is taken;
                    // one suppressed by a pause is re-issued from the same state.
                    if (commit_en_q) begin
                        state_d      = S_IDLE;
                        commit_cnt_d = commit_cnt_q + 32'd1;
                    end
                end
            endcase

            if (state_d == S_COMMIT || state_d == S_FLUSH) begin
                commit_en_d   = 1'b1;
                reg_wr_en_d   = (lat_rd_d != 5'd0) && (lat_type_d != TYPE_STORE);
                reg_wr_rd_d   = lat_rd_d;
                reg_wr_data_d = lat_value_d;
                reg_wr_tag_d  = lat_tag_d;
                if (state_d == S_FLUSH) begin
                    flush_d    = 1'b1;
                    flush_pc_d = lat_target_d;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lat_type_q    <= 2'd0;
            lat_rd_q      <= 5'd0;
            lat_value_q   <= 32'd0;
            lat_tag_q     <= '0;
            lat_target_q  <= 32'd0;
            commit_en_q   <= 1'b0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_rd_q   <= 5'd0;
            reg_wr_data_q <= 32'd0;
            reg_wr_tag_q  <= '0;
            store_req_q   <= 1'b0;
            flush_q       <= 1'b0;
            flush_pc_q    <= 32'd0;
            commit_cnt_q  <= 32'd0;
        end else begin
            state_q       <= state_d;
            lat_type_q    <= lat_type_d;
            lat_rd_q      <= lat_rd_d;
            lat_value_q   <= lat_value_d;
            lat_tag_q     <= lat_tag_d;
            lat_target_q  <= lat_target_d;
            commit_en_q   <= commit_en_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_rd_q   <= reg_wr_rd_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_wr_tag_q  <= reg_wr_tag_d;
            store_req_q   <= store_req_d;
            flush_q       <= flush_d;
            flush_pc_q    <= flush_pc_d;
            commit_cnt_q  <= commit_cnt_d;
        end
    end

    assign commit_en   = commit_en_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign reg_wr_rd   = reg_wr_rd_q;
    assign reg_wr_data = reg_wr_data_q;
    assign reg_wr_tag  = reg_wr_tag_q;
    assign store_req   = store_req_q;
    assign flush       = flush_q;
    assign flush_pc    = flush_pc_q;
    assign commit_cnt  = commit_cnt_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Testbench for commit_ctrl: directed scenarios plus randomized heads checked
// against expectations derived from the retirement rules (pulse timing,
// write-enable and flush rules, retired-instruction count).
`timescale 1ns/1ps
module tb_commit_ctrl;

    localparam int unsigned IW = 4;
    localparam int unsigned OW = 4 + 5 + 32 + IW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b0;
    logic          head_valid = 1'b0;
    logic          head_ready = 1'b0;
    logic [1:0]    head_type = 2'd0;
    logic          head_mispred = 1'b0;
    logic [4:0]    head_rd = 5'd0;
    logic [31:0]   head_value = 32'd0;
    logic [IW-1:0] head_tag = '0;
    logic [31:0]   head_target = 32'd0;
    logic          store_ack = 1'b0;
    logic          commit_en, reg_wr_en, store_req, flush;
    logic [4:0]    reg_wr_rd;
    logic [31:0]   reg_wr_data, flush_pc, commit_cnt;
    logic [IW-1:0] reg_wr_tag;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [31:0]   exp_cnt = 32'd0;

    commit_ctrl #(.ROB_IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .head_valid(head_valid), .head_ready(head_ready), .head_type(head_type),
        .head_mispred(head_mispred), .head_rd(head_rd), .head_value(head_value),
        .head_tag(head_tag), .head_target(head_target), .store_ack(store_ack),
        .commit_en(commit_en), .reg_wr_en(reg_wr_en), .reg_wr_rd(reg_wr_rd),
        .reg_wr_data(reg_wr_data), .reg_wr_tag(reg_wr_tag), .store_req(store_req),
        .flush(flush), .flush_pc(flush_pc), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OW-1:0] obs();
        return {commit_en, reg_wr_en, flush, store_req, reg_wr_rd, reg_wr_data, reg_wr_tag};
    endfunction

    function automatic logic [OW-1:0] mk(input logic ce, input logic we, input logic fl,
                                         input logic sr, input logic [4:0] rd,
                                         input logic [31:0] d, input logic [IW-1:0] t);
        return {ce, we, fl, sr, rd, d, t};
    endfunction

    task automatic drive_head(input logic [1:0] t, input logic m, input logic [4:0] rd,
                              input logic [31:0] v, input logic [IW-1:0] tg,
                              input logic [31:0] tgt);
        head_valid = 1'b1; head_ready = 1'b1;
        head_type = t; head_mispred = m; head_rd = rd;
        head_value = v; head_tag = tg; head_target = tgt;
    endtask

    task automatic scramble_head();
        head_type = 2'($urandom); head_mispred = 1'($urandom); head_rd = 5'($urandom);
        head_value = $urandom; head_tag = IW'($urandom); head_target = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'($urandom); store_ack = 1'b1;
        drive_head(2'd2, 1'b1, 5'd3, 32'hdead, 4'd1, 32'h40);
        step(); step();
        n_cmp++;
        if (obs() !== '0 || flush_pc !== 32'd0 || commit_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL reset: obs=%h flush_pc=%h cnt=%h, want all zero", obs(), flush_pc, commit_cnt);
        end
        rst = 1'b0; rdy = 1'b1; head_valid = 1'b0; store_ack = 1'b0; exp_cnt = 32'd0;
    endtask

    task automatic test_alu_basic();
        drive_head(2'd0, 1'b0, 5'd5, 32'h1234, 4'd3, 32'h0);
        step();
        head_valid = 1'b0;
        n_cmp++;
        if (obs() !== mk(1, 1, 0, 0, 5'd5, 32'h1234, 4'd3)) begin
            n_bad++;
            $display("FAIL alu_basic: got %h want %h", obs(), mk(1, 1, 0, 0, 5'd5, 32'h1234, 4'd3));
        end
        exp_cnt++;
        step();
        n_cmp++;
        if (commit_en !== 1'b0 || commit_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL alu_basic_after: commit_en=%b cnt=%0d want 0/%0d", commit_en, commit_cnt, exp_cnt);
        end
    endtask

    task automatic test_rd_zero();
        logic [31:0] v;
        v = $urandom;
        drive_head(2'd0, 1'b0, 5'd0, v, 4'd7, 32'h0);
        step();
        head_valid = 1'b0;
        n_cmp++;
        if (obs() !== mk(1, 0, 0, 0, 5'd0, v, 4'd7)) begin
            n_bad++;
            $display("FAIL rd_zero: got %h want %h", obs(), mk(1, 0, 0, 0, 5'd0, v, 4'd7));
        end
        exp_cnt++;
        step();
    endtask

    task automatic test_store();
        int hi;
        logic saw_ce;
        logic [31:0] v;
        // ack while idle must not start anything
        store_ack = 1'b1;
        step(); step();
        n_cmp++;
        if ({commit_en, store_req, reg_wr_en} !== 3'b000) begin
            n_bad++;
            $display("FAIL ack_idle: ce/sr/we=%b want 000", {commit_en, store_req, reg_wr_en});
        end
        store_ack = 1'b0;
        v = $urandom;
        drive_head(2'd1, 1'b0, 5'd9, v, 4'd2, 32'h0);
        step();
        head_valid = 1'b0;
        hi = 0; saw_ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (store_req === 1'b1) hi++;
            if (commit_en !== 1'b0) saw_ce = 1'b1;
            if (i == 3) store_ack = 1'b1;
            step();
        end
        store_ack = 1'b0;
        n_cmp++;
        if (hi != 4 || saw_ce !== 1'b0) begin
            n_bad++;
            $display("FAIL store_wait: store_req high %0d cycles, early commit=%b, want 4/0", hi, saw_ce);
        end
        n_cmp++;
        if (obs() !== mk(1, 0, 0, 0, 5'd9, v, 4'd2)) begin
            n_bad++;
            $display("FAIL store_commit: got %h want %h", obs(), mk(1, 0, 0, 0, 5'd9, v, 4'd2));
        end
        exp_cnt++;
        step();
        n_cmp++;
        if (commit_cnt !== exp_cnt || store_req !== 1'b0) begin
            n_bad++;
            $display("FAIL store_cnt: cnt=%0d sr=%b want %0d/0", commit_cnt, store_req, exp_cnt);
        end
    endtask

    task automatic test_flush();
        logic [31:0] v;
        v = $urandom;
        drive_head(2'd2, 1'b1, 5'd1, v, 4'd6, 32'h100);
        step();
        head_valid = 1'b0;
        n_cmp++;
        if (obs() !== mk(1, 1, 1, 0, 5'd1, v, 4'd6) || flush_pc !== 32'h100) begin
            n_bad++;
            $display("FAIL flush: got %h pc=%h want %h pc=100", obs(), flush_pc, mk(1, 1, 1, 0, 5'd1, v, 4'd6));
        end
        exp_cnt++;
        step();
        n_cmp++;
        if ({commit_en, flush, reg_wr_en} !== 3'b000 || commit_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL flush_after: ce/fl/we=%b cnt=%0d want 000/%0d", {commit_en, flush, reg_wr_en}, commit_cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        logic [1:0] t; logic m; logic [4:0] rd; logic [31:0] v, tgt; logic [IW-1:0] tg;
        logic we, fl, bad_wait; int d, r;
        for (int n = 0; n < 40; n++) begin
            // idle cycles where something blocks sampling
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                r = int'($urandom_range(0, 2));
                scramble_head();
                head_valid = (r != 0); head_ready = (r != 1); rdy = (r != 2);
                store_ack = 1'($urandom);
                step();
                n_cmp++;
                if ({commit_en, reg_wr_en, flush, store_req} !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL idle_hold: ce/we/fl/sr=%b want 0000 (pattern %0d)", {commit_en, reg_wr_en, flush, store_req}, r);
                end
            end
            rdy = 1'b1; store_ack = 1'b0;
            t = 2'($urandom); m = 1'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            v = $urandom; tg = IW'($urandom); tgt = $urandom;
            we = (rd != 5'd0) && (t != 2'd1);
            fl = (t == 2'd2) && m;
            drive_head(t, m, rd, v, tg, tgt);
            step();
            head_valid = 1'b0;
            scramble_head();
            if (t == 2'd1) begin
                d = int'($urandom_range(1, 5));
                bad_wait = 1'b0;
                for (int i = 0; i < d; i++) begin
                    if (store_req !== 1'b1 || commit_en !== 1'b0) bad_wait = 1'b1;
                    if (i == d - 1) store_ack = 1'b1;
                    step();
                end
                store_ack = 1'b0;
                n_cmp++;
                if (bad_wait) begin
                    n_bad++;
                    $display("FAIL rand_store_wait[%0d]: store_req not steady over %0d cycles", n, d);
                end
            end
            n_cmp++;
            if (obs() !== mk(1, we, fl, 0, rd, v, tg) || (fl && flush_pc !== tgt)) begin
                n_bad++;
                $display("FAIL rand_commit[%0d]: got %h pc=%h want %h pc=%h", n, obs(), flush_pc, mk(1, we, fl, 0, rd, v, tg), tgt);
            end
            exp_cnt++;
            step();
            n_cmp++;
            if ({commit_en, flush, reg_wr_en} !== 3'b000 || commit_cnt !== exp_cnt) begin
                n_bad++;
                $display("FAIL rand_after[%0d]: ce/fl/we=%b cnt=%0d want 000/%0d", n, {commit_en, flush, reg_wr_en}, commit_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] t; logic [4:0] rd; logic [31:0] v; logic [IW-1:0] tg;
        for (int k = 0; k < 20; k++) begin
            t = 2'($urandom);
            if (t == 2'd1) t = 2'd3;
            rd = 5'($urandom); v = $urandom; tg = IW'($urandom);
            drive_head(t, (t == 2'd2) ? 1'b0 : 1'($urandom), rd, v, tg, $urandom);
            step();
            // heads presented on even cycles are sampled; their pulse follows
            n_cmp++;
            if ((k % 2) == 0) begin
                if (obs() !== mk(1, rd != 5'd0, 0, 0, rd, v, tg)) begin
                    n_bad++;
                    $display("FAIL b2b_pulse[%0d]: got %h want %h", k, obs(), mk(1, rd != 5'd0, 0, 0, rd, v, tg));
                end
            end else if ({commit_en, reg_wr_en, flush} !== 3'b000) begin
                n_bad++;
                $display("FAIL b2b_gap[%0d]: ce/we/fl=%b want 000", k, {commit_en, reg_wr_en, flush});
            end
        end
        head_valid = 1'b0;
        exp_cnt = exp_cnt + 32'd10;
        n_cmp++;
        if (commit_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL b2b_cnt: cnt=%0d want %0d", commit_cnt, exp_cnt);
        end
        step();
    endtask

    task automatic test_rdy_stall();
        logic [31:0] v;
        v = $urandom;
        drive_head(2'd0, 1'b0, 5'd7, v, 4'd9, 32'h0);
        step();
        n_cmp++;
        if (obs() !== mk(1, 1, 0, 0, 5'd7, v, 4'd9)) begin
            n_bad++;
            $display("FAIL stall_first: got %h want %h", obs(), mk(1, 1, 0, 0, 5'd7, v, 4'd9));
        end
        rdy = 1'b0;
        drive_head(2'd2, 1'b1, 5'd30, ~v, 4'd4, 32'h200);
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({commit_en, reg_wr_en, flush} !== 3'b000 || commit_cnt !== exp_cnt) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: ce/we/fl=%b cnt=%0d want 000/%0d", i, {commit_en, reg_wr_en, flush}, commit_cnt, exp_cnt);
            end
        end
        rdy = 1'b1;
        step();
        head_valid = 1'b0;
        n_cmp++;
        if (obs() !== mk(1, 1, 0, 0, 5'd7, v, 4'd9)) begin
            n_bad++;
            $display("FAIL stall_reissue: got %h want %h", obs(), mk(1, 1, 0, 0, 5'd7, v, 4'd9));
        end
        exp_cnt++;
        step(); step();
        n_cmp++;
        if (commit_en !== 1'b0 || commit_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL stall_once: ce=%b cnt=%0d want 0/%0d", commit_en, commit_cnt, exp_cnt);
        end
        // paused STORE_WAIT keeps store_req and ignores ack
        drive_head(2'd1, 1'b0, 5'd2, v, 4'd5, 32'h0);
        step();
        head_valid = 1'b0;
        rdy = 1'b0; store_ack = 1'b1;
        step();
        n_cmp++;
        if ({store_req, commit_en} !== 2'b10) begin
            n_bad++;
            $display("FAIL stall_store: sr/ce=%b want 10", {store_req, commit_en});
        end
        rdy = 1'b1; store_ack = 1'b0;
        step();
        store_ack = 1'b1;
        step();
        store_ack = 1'b0;
        n_cmp++;
        if (obs() !== mk(1, 0, 0, 0, 5'd2, v, 4'd5)) begin
            n_bad++;
            $display("FAIL stall_store_commit: got %h want %h", obs(), mk(1, 0, 0, 0, 5'd2, v, 4'd5));
        end
        exp_cnt++;
        step();
    endtask

    task automatic test_reset_in_store();
        drive_head(2'd1, 1'b0, 5'd4, 32'h55, 4'd1, 32'h0);
        step();
        head_valid = 1'b0;
        n_cmp++;
        if (store_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_store_pre: store_req=%b want 1", store_req);
        end
        rst = 1'b1; rdy = 1'b0; store_ack = 1'b1;
        step();
        rst = 1'b0; rdy = 1'b1; store_ack = 1'b0; exp_cnt = 32'd0;
        n_cmp++;
        if (obs() !== '0 || commit_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_store: obs=%h cnt=%0d want 0/0", obs(), commit_cnt);
        end
        step(); step();
        n_cmp++;
        if ({commit_en, store_req} !== 2'b00 || commit_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL rst_store_after: ce/sr=%b cnt=%0d want 00/0", {commit_en, store_req}, commit_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_rd_zero();
        test_store();
        test_flush();
        test_random();
        test_back_to_back();
        test_rdy_stall();
        test_reset_in_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
